tarih: RTL and testbench

- Calendar date counter that consumes the day-carry pulses (gun_arttir / gun_azalt) produced by the hour counter.
- Holds day, month and year (2000–2099, stored as 0–99) with month-length and leap-year rules.
- Supports manual per-field editing while the clock is stopped, using the same button and lock scheme as the hour/minute counters.
- Feeds the display multiplexer.

---
 rtl/tarih_pkg.sv | 22 ++
 rtl/tarih_ay_uzunluk.sv | 22 ++
 rtl/tarih.sv | 145 ++++++++++++++
 tb/tb_tarih.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/tarih_pkg.sv
// Shared constants and helpers for the calendar date counter.
// Latency: not applicable (declarations only).
// Backpressure: not applicable (declarations only).
package tarih_pkg;

    // Edit field selector encodings
    localparam logic [1:0] ALAN_GUN = 2'd0;
    localparam logic [1:0] ALAN_AY  = 2'd1;
    localparam logic [1:0] ALAN_YIL = 2'd2;
    localparam logic [1:0] ALAN_YOK = 2'd3;

    // Field upper bounds
    localparam logic [4:0] GUN_MAX = 5'd31;
    localparam logic [3:0] AY_MAX  = 4'd12;
    localparam logic [6:0] YIL_MAX = 7'd99;

    // Within 2000-2099 every year divisible by 4 is a leap year (2000 included)
    function automatic logic artik_yil(input logic [6:0] yil);
        return (yil & 7'd3) == 7'd0;
    endfunction

endpackage

// File: rtl/tarih_ay_uzunluk.sv
// Month length lookup (28/29/30/31) for a given month and year offset.
// Latency: purely combinational, zero cycles.
// Backpressure: none, output follows inputs continuously.
module ay_uzunluk
    import tarih_pkg::*;
(
    input  logic [3:0] ay,
    input  logic [6:0] yil,
    output logic [4:0] len
);

    // Days in month; February depends on the leap-year rule
    always_comb begin
        len = GUN_MAX;
        case (ay)
            4'd4, 4'd6, 4'd9, 4'd11: len = 5'd30;
            4'd2:                    len = artik_yil(yil) ? 5'd29 : 5'd28;
            default:                 len = GUN_MAX;
        endcase
    end

endmodule

// File: rtl/tarih.sv
// Calendar date counter: day carries from the hour counter plus stopped-clock field editing.
// Latency: one clk from a qualifying input to the updated registered outputs.
// Backpressure: none; a lock allows one step per assertion, re-armed when all inputs are idle.
module tarih
    import tarih_pkg::*;
#(
    parameter int GUN_INIT = 1,
    parameter int AY_INIT  = 1,
    parameter int YIL_INIT = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       gun_arttir,
    input  logic       gun_azalt,
    input  logic       stop,
    input  logic       arttir_buton,
    input  logic       azalt_buton,
    input  logic [1:0] alan_sec,
    output logic [4:0] gun,
    output logic [3:0] ay,
    output logic [6:0] yil,
    output logic       yil_tasma
);

    logic       kontrol;
    logic       herhangi;
    logic       carry_act;
    logic       edit_act;
    logic [4:0] len_cur;
    logic [4:0] len_hedef;
    logic [3:0] hedef_ay;
    logic [6:0] hedef_yil;
    logic [4:0] gun_n;
    logic [3:0] ay_n;
    logic [6:0] yil_n;
    logic       tasma_n;

    assign herhangi  = gun_arttir | gun_azalt | arttir_buton | azalt_buton;
    // Any carry (even both at once) consumes the lock; buttons only when stopped and exactly one pressed
    assign carry_act = kontrol & (gun_arttir | gun_azalt);
    assign edit_act  = kontrol & ~(gun_arttir | gun_azalt) & stop & (arttir_buton ^ azalt_buton);

    ay_uzunluk u_len_cur (
        .ay  (ay),
        .yil (yil),
        .len (len_cur)
    );

    ay_uzunluk u_len_hedef (
        .ay  (hedef_ay),
        .yil (hedef_yil),
        .len (len_hedef)
    );

    // Target month/year: previous month on a day-1 borrow, edited month/year on a field edit
    always_comb begin
        hedef_ay  = ay;
        hedef_yil = yil;
        if (carry_act) begin
            if (gun_azalt && !gun_arttir && gun == 5'd1) begin
                hedef_ay = (ay == 4'd1) ? AY_MAX : ay - 4'd1;
                if (ay == 4'd1)
                    hedef_yil = (yil == 7'd0) ? YIL_MAX : yil - 7'd1;
            end
        end else if (edit_act) begin
            case (alan_sec)
                ALAN_AY:  hedef_ay  = arttir_buton ? ((ay == AY_MAX) ? 4'd1 : ay + 4'd1)
                                                   : ((ay == 4'd1) ? AY_MAX : ay - 4'd1);
                ALAN_YIL: hedef_yil = arttir_buton ? ((yil == YIL_MAX) ? 7'd0 : yil + 7'd1)
                                                   : ((yil == 7'd0) ? YIL_MAX : yil - 7'd1);
                default:  ;
            endcase
        end
    end

    // Next date: carry path has priority, edit path only when no carry is present
    always_comb begin
        gun_n   = gun;
        ay_n    = ay;
        yil_n   = yil;
        tasma_n = 1'b0;
        if (carry_act) begin
            if (gun_arttir && !gun_azalt) begin
                if (gun < len_cur) begin
                    gun_n = gun + 5'd1;
                end else begin
                    gun_n = 5'd1;
                    if (ay == AY_MAX) begin
                        ay_n = 4'd1;
                        if (yil == YIL_MAX) begin
                            yil_n   = 7'd0;
                            tasma_n = 1'b1;
                        end else begin
                            yil_n = yil + 7'd1;
                        end
                    end else begin
                        ay_n = ay + 4'd1;
                    end
                end
            end else if (gun_azalt && !gun_arttir) begin
                if (gun > 5'd1) begin
                    gun_n = gun - 5'd1;
                end else begin
                    ay_n    = hedef_ay;
                    yil_n   = hedef_yil;
                    gun_n   = len_hedef;
                    tasma_n = (ay == 4'd1) && (yil == 7'd0);
                end
            end
        end else if (edit_act) begin
            case (alan_sec)
                ALAN_GUN: gun_n = arttir_buton ? ((gun >= len_cur) ? 5'd1 : gun + 5'd1)
                                               : ((gun <= 5'd1) ? len_cur : gun - 5'd1);
                ALAN_AY, ALAN_YIL: begin
                    ay_n  = hedef_ay;
                    yil_n = hedef_yil;
                    gun_n = (gun > len_hedef) ? len_hedef : gun;
                end
                ALAN_YOK: ;
                default:  ;
            endcase
        end
    end

    // Date registers, overflow pulse and the one-step lock
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gun       <= 5'(GUN_INIT);
            ay        <= 4'(AY_INIT);
            yil       <= 7'(YIL_INIT);
            yil_tasma <= 1'b0;
            kontrol   <= 1'b1;
        end else begin
            gun       <= gun_n;
            ay        <= ay_n;
            yil       <= yil_n;
            yil_tasma <= tasma_n;
            if (!herhangi)
                kontrol <= 1'b1;
            else if (carry_act || edit_act)
                kontrol <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tarih.sv
// Scoreboard bench for the calendar date counter.
// Latency: checks the one-clk update latency of every step.
// Backpressure: none exercised; the lock is driven by held inputs.
module tb_tarih;
    import tarih_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       gun_arttir, gun_azalt, stop, arttir_buton, azalt_buton;
    logic [1:0] alan_sec;
    logic [4:0] gun;
    logic [3:0] ay;
    logic [6:0] yil;
    logic       yil_tasma;

    always #5 clk = ~clk;

    tarih #(.GUN_INIT(1), .AY_INIT(1), .YIL_INIT(24)) dut (
        .clk          (clk),
        .reset        (reset),
        .gun_arttir   (gun_arttir),
        .gun_azalt    (gun_azalt),
        .stop         (stop),
        .arttir_buton (arttir_buton),
        .azalt_buton  (azalt_buton),
        .alan_sec     (alan_sec),
        .gun          (gun),
        .ay           (ay),
        .yil          (yil),
        .yil_tasma    (yil_tasma)
    );

    typedef struct {
        int    due;
        string name;
        int    g;
        int    a;
        int    y;
        int    t;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    int   m_g = 1, m_a = 1, m_y = 24;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pop every expectation that has come due and compare against the outputs
    always @(negedge clk) begin : mon
        exp_t e;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            total++;
            if (int'(gun) != e.g || int'(ay) != e.a || int'(yil) != e.y || int'(yil_tasma) != e.t) begin
                bad++;
                $display("FAIL %s: got %0d/%0d/%0d tasma=%0d, want %0d/%0d/%0d tasma=%0d",
                         e.name, gun, ay, yil, yil_tasma, e.g, e.a, e.y, e.t);
            end
        end
    end

    // Queue an expected output d cycles from now and track it as the model date
    task automatic expect_d(input string n, input int g, input int a, input int y, input int t, input int d);
        exp_t e;
        e.due = cyc + d; e.name = n; e.g = g; e.a = a; e.y = y; e.t = t;
        sb.push_back(e);
        m_g = g; m_a = a; m_y = y;
    endtask

    task automatic step(input logic ga, input logic gz, input logic ab, input logic zb);
        @(posedge clk);
        #1;
        gun_arttir = ga; gun_azalt = gz; arttir_buton = ab; azalt_buton = zb;
    endtask

    task automatic press(input logic up);
        step(1'b0, 1'b0, up, !up);
        step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pulse(input logic up);
        step(up, !up, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Walk the date to g/a/y through edit mode, starting from the model date
    task automatic set_date(input int g, input int a, input int y);
        stop = 1'b1;
        alan_sec = ALAN_GUN;
        repeat (m_g - 1) press(1'b0);
        alan_sec = ALAN_YIL;
        repeat ((y - m_y + 100) % 100) press(1'b1);
        alan_sec = ALAN_AY;
        repeat ((a - m_a + 12) % 12) press(1'b1);
        alan_sec = ALAN_GUN;
        repeat (g - 1) press(1'b1);
        alan_sec = ALAN_YOK;
        expect_d("set_date", g, a, y, 0, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: got no finish by 1ms, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        gun_arttir = 0; gun_azalt = 0; stop = 0; arttir_buton = 0; azalt_buton = 0;
        alan_sec = ALAN_YOK;
        repeat (2) @(posedge clk);
        #1;
        expect_d("reset_state", 1, 1, 24, 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Leap-year month ends on the increment carry
        set_date(28, 2, 23);
        pulse(1'b1); expect_d("feb28_23_inc", 1, 3, 23, 0, 0);
        set_date(28, 2, 24);
        pulse(1'b1); expect_d("feb28_24_inc", 29, 2, 24, 0, 0);
        pulse(1'b1); expect_d("feb29_24_inc", 1, 3, 24, 0, 0);

        // Borrow into previous month and year underflow
        pulse(1'b0); expect_d("mar1_24_dec", 29, 2, 24, 0, 0);
        set_date(1, 1, 0);
        pulse(1'b0); expect_d("jan1_00_dec", 31, 12, 99, 1, 0);
        expect_d("tasma_dec_clear", 31, 12, 99, 0, 1);

        // Year overflow and held carry
        step(1'b0, 1'b0, 1'b0, 1'b0);
        pulse(1'b1); expect_d("dec31_99_inc", 1, 1, 0, 1, 0);
        expect_d("tasma_inc_clear", 1, 1, 0, 0, 1);
        step(1'b1, 1'b0, 1'b0, 1'b0); expect_d("hold_first", 2, 1, 0, 0, 1);
        repeat (9) step(1'b1, 1'b0, 1'b0, 1'b0);
        expect_d("hold_tenth", 2, 1, 0, 0, 1);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // Month edit clamps the day and does not restore it
        set_date(31, 1, 23);
        alan_sec = ALAN_AY;
        press(1'b1); expect_d("edit_ay_clamp", 28, 2, 23, 0, 0);
        press(1'b1); expect_d("edit_ay_noreturn", 28, 3, 23, 0, 0);
        alan_sec = ALAN_YIL;
        press(1'b0); expect_d("edit_yil_dec", 28, 3, 22, 0, 0);

        // Day edit wraps, double button, stopped-clock gating, carry priority
        set_date(30, 4, 23);
        alan_sec = ALAN_GUN;
        press(1'b1); expect_d("edit_gun_wrap_up", 1, 4, 23, 0, 0);
        press(1'b0); expect_d("edit_gun_wrap_dn", 30, 4, 23, 0, 0);
        step(1'b0, 1'b0, 1'b1, 1'b1); step(1'b0, 1'b0, 1'b0, 1'b0);
        expect_d("both_buttons", 30, 4, 23, 0, 0);
        stop = 1'b0;
        press(1'b1); expect_d("press_running", 30, 4, 23, 0, 0);
        stop = 1'b1;
        step(1'b1, 1'b0, 1'b1, 1'b0); step(1'b0, 1'b0, 1'b0, 1'b0);
        expect_d("carry_beats_button", 1, 5, 23, 0, 0);
        step(1'b1, 1'b1, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0, 1'b0);
        expect_d("both_carries", 1, 5, 23, 0, 0);
        step(1'b0, 1'b0, 1'b1, 1'b1); step(1'b0, 1'b0, 1'b1, 1'b0);
        expect_d("both_keeps_lock", 2, 5, 23, 0, 1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        alan_sec = ALAN_YOK;
        press(1'b1); expect_d("alan_yok", 2, 5, 23, 0, 0);

        // Asynchronous reset in the middle of a carry
        step(1'b1, 1'b0, 1'b0, 1'b0);
        #2;
        reset = 1'b0;
        expect_d("reset_async", 1, 1, 24, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        expect_d("reset_hold", 1, 1, 24, 0, 0);
        reset = 1'b1;
        expect_d("reset_resume", 2, 1, 24, 0, 1);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        repeat (4) @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL pending: got %0d unchecked, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
